// File: rtl/fifo_stream_reader.sv
// Read-side master for the block-RAM FIFO: issues credit-limited reads and
// presents the registered FIFO output as a valid/ready stream via a 2-entry skid buffer.
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 fifo_rd_en,
    output logic                 m_valid,
    output logic [WIDTH-1:0]     m_data,
    input  logic                 m_ready,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] words_out
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [1:0]           occ_q, occ_d;
    logic                 inflight_q, inflight_d;
    logic [WIDTH-1:0]     head_q, head_d;
    logic [WIDTH-1:0]     tail_q, tail_d;
    logic [CNT_WIDTH-1:0] words_q, words_d;

    logic       pop;
    logic [1:0] credit_used;

    assign m_valid   = (occ_q != 2'd0);
    assign m_data    = head_q;
    assign words_out = words_q;

    // A read is only issued when the word it returns is guaranteed a slot,
    // counting the slot freed by a pop in this same cycle.
    always_comb begin
        pop         = m_valid && m_ready;
        credit_used = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        fifo_rd_en  = n_reset && !flush && !fifo_empty && (credit_used < 2'd2);
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        occ_d      = occ_q;
        inflight_d = fifo_rd_en;
        head_d     = head_q;
        tail_d     = tail_q;
        words_d    = words_q;

        if (flush) begin
            occ_d      = 2'd0;
            inflight_d = 1'b0;
        end else begin
            if (pop) begin
                words_d = words_q + CNT_ONE;
            end
            case (occ_q)
                2'd0: begin
                    if (inflight_q) begin
                        head_d = fifo_data;
                        occ_d  = 2'd1;
                    end
                end
                2'd1: begin
                    if (inflight_q && pop) begin
                        head_d = fifo_data;
                    end else if (inflight_q) begin
                        tail_d = fifo_data;
                        occ_d  = 2'd2;
                    end else if (pop) begin
                        occ_d = 2'd0;
                    end
                end
                default: begin
                    // Full buffer: a capture can only coincide with a pop here.
                    if (pop) begin
                        head_d = tail_q;
                        if (inflight_q) begin
                            tail_d = fifo_data;
                        end else begin
                            occ_d = 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: the two data registers are reset as well, so m_data reads 0 after reset rather than stale data.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
        if (!n_reset) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            words_q    <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            words_q    <= words_d;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: a directed vector table driving the FIFO pins directly,
// then sequences against a behavioural FIFO with an in-order scoreboard.
module tb_fifo_stream_reader;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;   // narrow counter so the wrap is exercised in a short run

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             n_reset, flush, m_ready;
    logic             fifo_empty, fifo_rd_en, m_valid;
    logic [WIDTH-1:0] fifo_data, m_data;
    logic [CNT_W-1:0] words_out;

    logic             use_model, drv_empty, mdl_empty, wr_en;
    logic [WIDTH-1:0] drv_data, mdl_dout, wr_data;
    logic [WIDTH-1:0] mdl_q[$];
    logic [WIDTH-1:0] exp_q[$];
    int               in_dut = 0;
    logic [CNT_W-1:0] words_exp;
    int               vectors = 0;
    int               errors  = 0;
    int               pulses;

    assign fifo_empty = use_model ? mdl_empty : drv_empty;
    assign fifo_data  = use_model ? mdl_dout  : drv_data;

    fifo_stream_reader #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_W)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .flush      (flush),
        .words_out  (words_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural synchronous FIFO: registered data_out, reads ignored while empty.
    always @(posedge clk) begin
        if (use_model) begin
            if (fifo_rd_en && mdl_q.size() > 0) mdl_dout <= mdl_q.pop_front();
            if (wr_en) mdl_q.push_back(wr_data);
            mdl_empty <= (mdl_q.size() == 0);
        end else begin
            mdl_q.delete();
            mdl_empty <= 1'b1;
        end
    end

    // Scoreboard and invariants, sampled mid-cycle for the edge that follows.
    always @(negedge clk) begin
        if (use_model && wr_en) exp_q.push_back(wr_data);
        if (!n_reset) begin
            check("rd_en_in_reset", 32'(fifo_rd_en), 0);
            words_exp = '0;
        end
        if (use_model) begin
            if (!n_reset || flush) begin
                while (in_dut > 0 && exp_q.size() > 0) begin
                    exp_q.delete(0);
                    in_dut--;
                end
                in_dut = 0;
            end else begin
                check("credit_bound", 32'(int'(dut.occ_q) + int'(dut.inflight_q) <= 2), 1);
                check("rd_en_while_empty", 32'(fifo_rd_en && fifo_empty), 0);
                if (m_valid && m_ready) begin
                    check("word_pending", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        check("stream_word", 32'(m_data), 32'(exp_q[0]));
                        exp_q.delete(0);
                    end
                    words_exp = words_exp + CNT_W'(1);
                    in_dut--;
                end
                if (fifo_rd_en && !fifo_empty) in_dut++;
            end
        end
    end

    typedef struct {
        logic             n_reset;
        logic             empty;
        logic [WIDTH-1:0] data;
        logic             ready;
        logic             flush;
        logic             rd_en;
        logic             valid;
        logic [WIDTH-1:0] mdata;
        logic [CNT_W-1:0] words;
    } vec_t;

    vec_t tbl[18];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            nrst  empty data   rdy   fl  | rd_en valid mdata  words
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0};
        tbl[1]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0};
        tbl[2]  = '{1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 4'd0};
        tbl[3]  = '{1'b1, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 4'd1};
        tbl[4]  = '{1'b1, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hF0, 4'd2};
        tbl[5]  = '{1'b1, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF0, 4'd3};
        tbl[6]  = '{1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 4'd3};
        tbl[7]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 4'd3};
        tbl[8]  = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 4'd3};
        tbl[9]  = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 4'd3};
        tbl[10] = '{1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 4'd3};
        tbl[11] = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 4'd3};
        tbl[12] = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 4'd4};
        tbl[13] = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 4'd5};
        tbl[14] = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 4'd5};
        tbl[15] = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 4'd5};
        tbl[16] = '{1'b0, 1'b0, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 4'd5};
        tbl[17] = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};

        n_reset = 1'b0; flush = 1'b0; m_ready = 1'b0;
        use_model = 1'b0; wr_en = 1'b0; wr_data = '0;
        drv_empty = 1'b1; drv_data = '0;
        tick();
        tick();
        check("reset_valid", 32'(m_valid), 0);
        check("reset_data", 32'(m_data), 0);
        check("reset_words", 32'(words_out), 0);

        for (int i = 0; i < 18; i++) begin
            n_reset   = tbl[i].n_reset;
            drv_empty = tbl[i].empty;
            drv_data  = tbl[i].data;
            m_ready   = tbl[i].ready;
            flush     = tbl[i].flush;
            #1;
            check($sformatf("v%0d_rd_en", i), 32'(fifo_rd_en), 32'(tbl[i].rd_en));
            check($sformatf("v%0d_valid", i), 32'(m_valid), 32'(tbl[i].valid));
            check($sformatf("v%0d_data", i), 32'(m_data), 32'(tbl[i].mdata));
            check($sformatf("v%0d_words", i), 32'(words_out), 32'(tbl[i].words));
            tick();
        end

        n_reset = 1'b0; flush = 1'b0; m_ready = 1'b0; use_model = 1'b1;
        tick();
        tick();
        n_reset = 1'b1;

        // Five words with the consumer stalled: only two reads may be issued.
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            wr_en = (i < 5);
            wr_data = 8'h50 + 8'(i);
            #1;
            if (fifo_rd_en) pulses++;
            tick();
        end
        wr_en = 1'b0;
        check("s2_rd_pulses", 32'(pulses), 2);
        check("s2_hold_valid", 32'(m_valid), 1);
        check("s2_hold_data", 32'(m_data), 32'h50);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("s2_burst%0d_valid", i), 32'(m_valid), 1);
            check($sformatf("s2_burst%0d_data", i), 32'(m_data), 32'h50 + 32'(i));
            tick();
        end
        #1;
        check("s2_empty_after", 32'(m_valid), 0);
        check("s2_words", 32'(words_out), 32'(words_exp));

        // Alternating ready with one FIFO write per cycle.
        for (int i = 0; i < 100; i++) begin
            m_ready = (i % 2 == 0);
            wr_en = (i < 20);
            wr_data = 8'h60 + 8'(i);
            tick();
            if (i >= 20 && exp_q.size() == 0) break;
        end
        wr_en = 1'b0;
        check("s3_drained", 32'(exp_q.size()), 0);
        check("s3_valid_low", 32'(m_valid), 0);
        check("s3_words", 32'(words_out), 32'(words_exp));

        // Idle after draining, then a lone word.
        m_ready = 1'b1;
        repeat (3) tick();
        check("s4_idle_valid", 32'(m_valid), 0);
        check("s4_idle_data", 32'(m_data), 32'h73);
        wr_en = 1'b1; wr_data = 8'h77;
        tick();
        wr_en = 1'b0;
        #1;
        check("s4_t0_nonempty", 32'(fifo_empty), 0);
        check("s4_t0_valid", 32'(m_valid), 0);
        tick();
        check("s4_t1_valid", 32'(m_valid), 0);
        tick();
        check("s4_t2_valid", 32'(m_valid), 1);
        check("s4_t2_data", 32'(m_data), 32'h77);
        tick();
        check("s4_after_valid", 32'(m_valid), 0);

        // Flush with one word buffered and one in flight.
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h80 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        repeat (4) tick();
        check("s5_full_occ", 32'(dut.occ_q), 2);
        check("s5_full_data", 32'(m_data), 32'h80);
        m_ready = 1'b1;
        tick();
        flush = 1'b1;
        #1;
        check("s5_flush_rd_en", 32'(fifo_rd_en), 0);
        check("s5_flush_occ", 32'(dut.occ_q), 1);
        check("s5_flush_inflight", 32'(dut.inflight_q), 1);
        tick();
        flush = 1'b0;
        check("s5_post_valid", 32'(m_valid), 0);
        check("s5_post_words", 32'(words_out), 32'(words_exp));
        for (int i = 0; i < 30; i++) begin
            tick();
            if (exp_q.size() == 0) break;
        end
        check("s5_drained", 32'(exp_q.size()), 0);
        check("s5_words", 32'(words_out), 32'(words_exp));

        // One-cycle reset in the middle of a burst.
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h90 + 8'(i);
            n_reset = (i != 4);
            #1;
            if (i == 4) check("s6_rst_rd_en", 32'(fifo_rd_en), 0);
            if (i == 5) begin
                check("s6_post_valid", 32'(m_valid), 0);
                check("s6_post_words", 32'(words_out), 0);
            end
            tick();
        end
        wr_en = 1'b0;
        n_reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (exp_q.size() == 0) break;
        end
        check("s6_drained", 32'(exp_q.size()), 0);
        check("s6_words", 32'(words_out), 32'(words_exp));
        check("s6_valid_low", 32'(m_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
